// File: rtl/axis_traffic_gen_pkg.sv
// Shared types and constants for the NoC traffic generator: traffic modes,
// controller states and the LFSR feedback polynomial.
package noc_tg_pkg;

    typedef enum logic [1:0] {
        UNIFORM    = 2'd0,
        COMPLEMENT = 2'd1,
        NEIGHBOUR  = 2'd2,
        HOTSPOT    = 2'd3
    } tg_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } tg_state_e;

    // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/axis_traffic_gen_if.sv
// AXI4-Stream channel bundle used between the traffic generator and its sink.
interface axis_if #(
    parameter int TDATA_WIDTH = 64,
    parameter int TID_WIDTH   = 2,
    parameter int TDEST_WIDTH = 2
);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tlast;
    logic [TID_WIDTH-1:0]   tid;
    logic [TDEST_WIDTH-1:0] tdest;

    modport master (output tvalid, tdata, tlast, tid, tdest, input tready);
    modport slave  (input tvalid, tdata, tlast, tid, tdest, output tready);
endinterface

// File: rtl/axis_traffic_gen_lfsr.sv
// 32-bit Galois LFSR that steps only while enabled; a zero seed is replaced
// by 1 so the register can never lock up.
module lfsr32
    import noc_tg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] seed,
    output logic [31:0] value
);

    logic [31:0] state_r;
    logic [31:0] seed_s;

    assign seed_s = (seed == 32'd0) ? 32'd1 : seed;

    // Pseudo-random state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= seed_s;
        end else if (en) begin
            state_r <= lfsr_step(state_r);
        end else begin
            state_r <= state_r;
        end
    end

    assign value = state_r;

endmodule

// File: rtl/axis_traffic_gen.sv
// Synthetic NoC traffic source: injects fixed-length AXIS packets with a
// programmable probability and destination pattern, counting what it sends.
module axis_traffic_gen
    import noc_tg_pkg::*;
#(
    parameter int TID          = 0,
    parameter int SEED         = 1,
    parameter int TDATA_WIDTH  = 64,
    parameter int TDEST_WIDTH  = 2,
    parameter int TID_WIDTH    = 2,
    parameter int COUNT_WIDTH  = 32,
    parameter int NUM_ROUTERS  = 4,
    parameter int MAX_PKT_LEN  = 16,
    parameter int HOTSPOT_DEST = 0,
    localparam int LEN_W       = $clog2(MAX_PKT_LEN + 1),
    localparam int HALF_W      = TDATA_WIDTH / 2
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     start,
    input  logic [1:0]                               mode,
    input  logic [15:0]                              load,
    input  logic [LEN_W-1:0]                         pkt_len,
    input  logic [COUNT_WIDTH-1:0]                   num_packets,
    input  logic [HALF_W-1:0]                        ticks,
    output logic                                     done,
    output logic [COUNT_WIDTH-1:0]                   total_sent_packets,
    output logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0]  sent_packets,
    axis_if.master                                   axis_out
);

    tg_state_e                              state_r;
    tg_mode_e                               mode_r;
    logic [15:0]                            load_r;
    logic [7:0]                             len_r;
    logic [COUNT_WIDTH-1:0]                 num_r;
    logic [COUNT_WIDTH-1:0]                 run_cnt_r;
    logic [COUNT_WIDTH-1:0]                 total_r;
    logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0] sent_r;
    logic                                   tvalid_r;
    logic                                   tlast_r;
    logic                                   done_r;
    logic [7:0]                             flit_r;
    logic [TDEST_WIDTH-1:0]                 dest_r;
    logic [HALF_W-1:0]                      ts_r;
    logic [HALF_W-9:0]                      seq_r;

    logic [31:0]                            lfsr_val_s;
    logic                                   lfsr_en_s;
    logic                                   inject_s;
    logic [TDEST_WIDTH-1:0]                 dest_s;
    logic [COUNT_WIDTH-1:0]                 run_next_s;

    function automatic logic [7:0] eff_len(input logic [LEN_W-1:0] p);
        if (p == '0) begin
            return 8'd1;
        end else if (32'(p) > MAX_PKT_LEN) begin
            return 8'(MAX_PKT_LEN);
        end else begin
            return 8'(p);
        end
    endfunction

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
        return (&c) ? c : c + COUNT_WIDTH'(1);
    endfunction

    lfsr32 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (lfsr_en_s),
        .seed  (32'(SEED)),
        .value (lfsr_val_s)
    );

    assign lfsr_en_s  = (state_r == GEN);
    assign inject_s   = (load_r == 16'hFFFF) || (lfsr_val_s[15:0] < load_r);
    assign run_next_s = sat_inc(run_cnt_r);

    // Destination chosen by the traffic pattern latched at start
    always_comb begin
        dest_s = '0;
        case (mode_r)
            UNIFORM:    dest_s = TDEST_WIDTH'(32'(lfsr_val_s[31:16]) % 32'(NUM_ROUTERS));
            COMPLEMENT: dest_s = TDEST_WIDTH'(NUM_ROUTERS - 1 - TID);
            NEIGHBOUR:  dest_s = TDEST_WIDTH'((TID + 1) % NUM_ROUTERS);
            HOTSPOT:    dest_s = TDEST_WIDTH'(HOTSPOT_DEST);
            default:    dest_s = '0;
        endcase
    end

    // Controller FSM with registered AXIS payload, status and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            mode_r    <= UNIFORM;
            load_r    <= 16'd0;
            len_r     <= 8'd1;
            num_r     <= '0;
            run_cnt_r <= '0;
            total_r   <= '0;
            sent_r    <= '0;
            tvalid_r  <= 1'b0;
            tlast_r   <= 1'b0;
            done_r    <= 1'b0;
            flit_r    <= 8'd0;
            dest_r    <= '0;
            ts_r      <= '0;
            seq_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        mode_r    <= tg_mode_e'(mode);
                        load_r    <= load;
                        len_r     <= eff_len(pkt_len);
                        num_r     <= num_packets;
                        run_cnt_r <= '0;
                        state_r   <= GEN;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                GEN: begin
                    if (!start) begin
                        state_r <= IDLE;
                    end else if (run_cnt_r >= num_r) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end else if (inject_s) begin
                        state_r  <= SEND;
                        tvalid_r <= 1'b1;
                        tlast_r  <= (len_r == 8'd1);
                        flit_r   <= 8'd0;
                        dest_r   <= dest_s;
                        ts_r     <= ticks;
                        seq_r    <= sent_r[dest_s][HALF_W-9:0];
                    end else begin
                        state_r <= GEN;
                    end
                end
                SEND: begin
                    // The packet always runs to completion; start is only
                    // consulted once the last flit has been accepted.
                    if (tvalid_r && axis_out.tready) begin
                        if (tlast_r) begin
                            tvalid_r       <= 1'b0;
                            tlast_r        <= 1'b0;
                            flit_r         <= 8'd0;
                            total_r        <= sat_inc(total_r);
                            sent_r[dest_r] <= sat_inc(sent_r[dest_r]);
                            run_cnt_r      <= run_next_s;
                            if (run_next_s >= num_r) begin
                                state_r <= DONE;
                                done_r  <= 1'b1;
                            end else if (!start) begin
                                state_r <= IDLE;
                            end else begin
                                state_r <= GEN;
                            end
                        end else begin
                            flit_r  <= flit_r + 8'd1;
                            tlast_r <= ((flit_r + 8'd2) == len_r);
                        end
                    end else begin
                        state_r <= SEND;
                    end
                end
                DONE: begin
                    if (!start) begin
                        done_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign done               = done_r;
    assign total_sent_packets = total_r;
    assign sent_packets       = sent_r;
    assign axis_out.tvalid    = tvalid_r;
    assign axis_out.tlast     = tlast_r;
    assign axis_out.tdata     = {ts_r, seq_r, flit_r};
    assign axis_out.tdest     = dest_r;
    assign axis_out.tid       = TID_WIDTH'(TID);

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Self-checking bench for axis_traffic_gen: table of deterministic runs plus
// hand-written stall, idle-load, early-stop and reset-replay sequences.
module tb_axis_traffic_gen;
    import noc_tg_pkg::*;

    localparam int TDW    = 64;
    localparam int TDEST_W = 2;
    localparam int TID_W  = 2;
    localparam int CW     = 32;
    localparam int NR     = 4;
    localparam int MAXL   = 16;
    localparam int HOT    = 3;
    localparam int TIDP   = 1;
    localparam int SEEDP  = 1;
    localparam int LEN_W  = $clog2(MAXL + 1);
    localparam int HALF   = TDW / 2;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       start;
    logic [1:0]                 mode;
    logic [15:0]                load;
    logic [LEN_W-1:0]           pkt_len;
    logic [CW-1:0]              num_packets;
    logic [HALF-1:0]            ticks;
    logic                       done;
    logic [CW-1:0]              total;
    logic [NR-1:0][CW-1:0]      sent;

    axis_if #(.TDATA_WIDTH(TDW), .TID_WIDTH(TID_W), .TDEST_WIDTH(TDEST_W)) axis_out ();

    axis_traffic_gen #(
        .TID(TIDP), .SEED(SEEDP), .TDATA_WIDTH(TDW), .TDEST_WIDTH(TDEST_W),
        .TID_WIDTH(TID_W), .COUNT_WIDTH(CW), .NUM_ROUTERS(NR),
        .MAX_PKT_LEN(MAXL), .HOTSPOT_DEST(HOT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .load(load),
        .pkt_len(pkt_len), .num_packets(num_packets), .ticks(ticks),
        .done(done), .total_sent_packets(total), .sent_packets(sent),
        .axis_out(axis_out.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TDW-1:0]     data;
        logic [TDEST_W-1:0] dest;
        logic               last;
    } flit_t;

    typedef struct {
        int mode;
        int plen;
        int npk;
        int elen;
        int edest;   // -2: predicted from LFSR model, >=0: fixed destination
    } vec_t;

    flit_t              fq[$];
    vec_t               tbl[8];
    int                 checks = 0;
    int                 errors = 0;
    bit                 rand_ready = 1'b0;
    logic               prev_stall = 1'b0;
    logic [TDW-1:0]     prev_data;
    logic [TDEST_W-1:0] prev_dest;
    logic               prev_last;
    int                 tvalid_seen = 0;
    int                 model_cnt[NR];
    logic [31:0]        mlfsr;
    logic [TDEST_W-1:0] ref_dest[$];
    logic [HALF-1:0]    ref_low[$];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // One step of the x^32+x^22+x^2+x+1 generator, feedback from bit 0
    function automatic logic [31:0] lfsr_model(input logic [31:0] v);
        logic fb;
        fb = v[0];
        v  = v >> 1;
        if (fb) begin
            v[31] = ~v[31];
            v[21] = ~v[21];
            v[1]  = ~v[1];
            v[0]  = ~v[0];
        end
        return v;
    endfunction

    task automatic cycle();
        if (rand_ready) axis_out.tready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (prev_stall) begin
            check("stall_tvalid", axis_out.tvalid, 1'b1);
            check("stall_tdata", axis_out.tdata, prev_data);
            check("stall_tdest", axis_out.tdest, prev_dest);
            check("stall_tlast", axis_out.tlast, prev_last);
        end
        if (axis_out.tvalid === 1'b1) tvalid_seen++;
        if (axis_out.tvalid === 1'b1 && axis_out.tready === 1'b1)
            fq.push_back('{data: axis_out.tdata, dest: axis_out.tdest, last: axis_out.tlast});
        prev_stall = (axis_out.tvalid === 1'b1) && (axis_out.tready === 1'b0);
        prev_data  = axis_out.tdata;
        prev_dest  = axis_out.tdest;
        prev_last  = axis_out.tlast;
        @(posedge clk);
        #1;
        ticks = ticks + 32'd1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        prev_stall = 1'b0;
        fq.delete();
        foreach (model_cnt[d]) model_cnt[d] = 0;
        mlfsr       = 32'(SEEDP);
        tvalid_seen = 0;
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            cycle();
            n++;
        end
        check("done_within_budget", done, 1'b1);
    endtask

    // Walks the accepted flits packet by packet against the packet rules
    task automatic check_stream(input int elen, input int edest);
        int                 idx = 0;
        logic [TDEST_W-1:0] d = '0;
        logic [HALF-1:0]    ts = '0;
        logic [HALF-9:0]    sq = '0;
        foreach (fq[i]) begin
            if (idx == 0) begin
                d  = fq[i].dest;
                ts = fq[i].data[TDW-1:HALF];
                sq = fq[i].data[HALF-1:8];
                if (edest == -2) begin
                    check("dest_lfsr", d, (mlfsr >> 16) % NR);
                    mlfsr = lfsr_model(mlfsr);
                end else if (edest >= 0) begin
                    check("dest_rule", d, edest);
                end else begin
                    check("dest_range", (int'(d) < NR), 1'b1);
                end
                check("seq", sq, model_cnt[d]);
            end else begin
                check("dest_const", fq[i].dest, d);
                check("ts_const", fq[i].data[TDW-1:HALF], ts);
                check("seq_const", fq[i].data[HALF-1:8], sq);
            end
            check("flit_idx", fq[i].data[7:0], idx);
            check("tlast", fq[i].last, (idx == elen - 1));
            if (idx == elen - 1) begin
                model_cnt[d]++;
                idx = 0;
            end else begin
                idx++;
            end
        end
        check("stream_whole_packets", idx, 0);
    endtask

    task automatic check_counters();
        int sum = 0;
        foreach (model_cnt[d]) begin
            sum += model_cnt[d];
            check("sent_packets", sent[d], model_cnt[d]);
        end
        check("total_sent", total, sum);
    endtask

    initial begin
        tbl[0] = '{2, 3, 10, 3, 2};
        tbl[1] = '{1, 1, 4, 1, 2};
        tbl[2] = '{3, 0, 3, 1, HOT};
        tbl[3] = '{3, MAXL + 5, 2, MAXL, HOT};
        tbl[4] = '{2, MAXL, 1, MAXL, 2};
        tbl[5] = '{0, 2, 6, 2, -2};
        tbl[6] = '{2, 5, 0, 5, 2};
        tbl[7] = '{1, 7, 3, 7, 2};

        rst_n = 1'b0; start = 1'b0; mode = 2'd0; load = 16'd0; pkt_len = '0;
        num_packets = '0; ticks = '0; axis_out.tready = 1'b1;
        #2;
        check("rst_tvalid", axis_out.tvalid, 1'b0);
        check("rst_tlast", axis_out.tlast, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_tdata", axis_out.tdata, 64'd0);
        check("rst_tdest", axis_out.tdest, 0);
        check("rst_tid", axis_out.tid, TIDP);
        check("rst_total", total, 0);
        do_reset();

        // Deterministic full-load runs
        for (int i = 0; i < 8; i++) begin
            do_reset();
            mode        = 2'(tbl[i].mode);
            load        = 16'hFFFF;
            pkt_len     = LEN_W'(tbl[i].plen);
            num_packets = CW'(tbl[i].npk);
            axis_out.tready = 1'b1;
            start = 1'b1;
            run_until_done(400);
            check("flit_count", fq.size(), tbl[i].elen * tbl[i].npk);
            check_stream(tbl[i].elen, tbl[i].edest);
            check_counters();
            start = 1'b0;
            cycle();
            cycle();
            check("done_clears", done, 1'b0);
        end

        // Random back-pressure with random load
        do_reset();
        mode = 2'd0; load = 16'($urandom_range(16'h2000, 16'hE000));
        pkt_len = LEN_W'(4); num_packets = 32'd8;
        rand_ready = 1'b1; start = 1'b1;
        run_until_done(3000);
        rand_ready = 1'b0; axis_out.tready = 1'b1;
        check("rand_flit_count", fq.size(), 32);
        check_stream(4, -1);
        check_counters();
        start = 1'b0;
        cycle();

        // Zero load never injects
        do_reset();
        mode = 2'd0; load = 16'd0; pkt_len = LEN_W'(2); num_packets = 32'd5; start = 1'b1;
        repeat (1000) cycle();
        check("load0_tvalid_seen", tvalid_seen, 0);
        check("load0_total", total, 0);
        check("load0_done", done, 1'b0);
        check_counters();
        start = 1'b0;
        cycle();

        // start dropped while flit 1 of a 4-flit packet is pending
        do_reset();
        mode = 2'd2; load = 16'hFFFF; pkt_len = LEN_W'(4); num_packets = 32'd100; start = 1'b1;
        for (int n = 0; n < 50 && fq.size() < 1; n++) cycle();
        check("stop_mid_packet", axis_out.tvalid, 1'b1);
        start = 1'b0;
        repeat (12) cycle();
        check("stop_flit_count", fq.size(), 4);
        check_stream(4, 2);
        check("stop_total", total, 1);
        check("stop_done", done, 1'b0);
        check("stop_tvalid_low", axis_out.tvalid, 1'b0);

        // Reset mid-packet then replay from the same seed
        do_reset();
        mode = 2'd0; load = 16'hFFFF; pkt_len = LEN_W'(3); num_packets = 32'd50; start = 1'b1;
        for (int n = 0; n < 100 && fq.size() < 13; n++) cycle();
        check("pre_reset_flits", fq.size(), 13);
        for (int i = 0; i < 12 && i < fq.size(); i++) begin
            ref_dest.push_back(fq[i].dest);
            ref_low.push_back(fq[i].data[HALF-1:0]);
        end
        rst_n = 1'b0;
        #1;
        check("async_rst_tvalid", axis_out.tvalid, 1'b0);
        check("async_rst_total", total, 0);
        check("async_rst_done", done, 1'b0);
        for (int d = 0; d < NR; d++) check("async_rst_sent", sent[d], 0);
        do_reset();
        start = 1'b1;
        for (int n = 0; n < 100 && fq.size() < 12; n++) cycle();
        check("replay_flits", fq.size(), 12);
        for (int i = 0; i < ref_dest.size() && i < fq.size(); i++) begin
            check("replay_dest", fq[i].dest, ref_dest[i]);
            check("replay_seq_idx", fq[i].data[HALF-1:0], ref_low[i]);
        end
        check_stream(3, -2);
        start = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
